exec_stage: RTL and testbench

Registered execute stage of the single-cycle-derived 64-bit ARM (LEGv8-style) core. It decodes the 2-bit ALUOp and the instruction opcode field into a 4-bit ALU operation, and performs that operation on two 64-bit operands. It also computes the sequential PC (PC+4) and the branch target (PC + offset·4). All results are captured in one output register stage, so the stage has a fixed one-cycle latency.

---
 rtl/exec_stage_if.sv | 39 +++
 rtl/exec_stage.sv | 115 +++++++++++
 tb/tb_exec_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_stage_if
// Description : Bundle of execute-stage operation inputs and registered
//               results. The master side presents operations and consumes
//               results; the slave side (the execute stage) does the reverse.
//   in_valid, alu_op, funct, op_a, op_b, pc, offset : operation inputs
//   out_valid, alu_ctl, result, zero, pc_plus4, branch_target : results
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_stage_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [1:0]        alu_op;
    logic [9:0]        funct;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] offset;

    logic              out_valid;
    logic [3:0]        alu_ctl;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] branch_target;

    modport master (
        output in_valid, alu_op, funct, op_a, op_b, pc, offset,
        input  out_valid, alu_ctl, result, zero, pc_plus4, branch_target
    );

    modport slave (
        input  in_valid, alu_op, funct, op_a, op_b, pc, offset,
        output out_valid, alu_ctl, result, zero, pc_plus4, branch_target
    );
endinterface
`default_nettype wire

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : exec_stage
// Description : Registered LEGv8 execute stage. Decodes ALUOp/opcode into a
//               4-bit ALU operation, runs the ALU on op_a/op_b, and computes
//               PC+4 and the branch target. Every output is registered, so
//               results appear one cycle after the inputs are sampled.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : exec_stage_if slave modport (operation in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module exec_stage #(
    parameter int DATA_W = 64
) (
    input  wire logic    clk,
    input  wire logic    reset,
    exec_stage_if.slave  bus
);

    // ALU operation codes
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_ORR = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_PSB = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;
    localparam logic [3:0] c_ALU_INV = 4'b1111;

    // R-type opcode field (instruction[31:22])
    localparam logic [9:0] c_FN_ADD = 10'b1000101100;
    localparam logic [9:0] c_FN_SUB = 10'b1100101100;
    localparam logic [9:0] c_FN_AND = 10'b1000101000;
    localparam logic [9:0] c_FN_ORR = 10'b1010101000;

    localparam logic [DATA_W-1:0] c_FOUR = DATA_W'(4);

    logic [3:0]        w_alu_ctl;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [DATA_W-1:0] w_branch_target;

    logic              r_out_valid;
    logic [3:0]        r_alu_ctl;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [DATA_W-1:0] r_branch_target;

    // ALU control decode
    always_comb begin
        w_alu_ctl = c_ALU_INV;
        unique case (bus.alu_op)
            2'b00: w_alu_ctl = c_ALU_ADD;
            2'b01: w_alu_ctl = c_ALU_PSB;
            2'b10: begin
                case (bus.funct)
                    c_FN_ADD: w_alu_ctl = c_ALU_ADD;
                    c_FN_SUB: w_alu_ctl = c_ALU_SUB;
                    c_FN_AND: w_alu_ctl = c_ALU_AND;
                    c_FN_ORR: w_alu_ctl = c_ALU_ORR;
                    default:  w_alu_ctl = c_ALU_INV;
                endcase
            end
            default: w_alu_ctl = c_ALU_INV;
        endcase
    end

    // ALU datapath; unlisted codes produce zero
    always_comb begin
        w_result = '0;
        case (w_alu_ctl)
            c_ALU_AND: w_result = bus.op_a & bus.op_b;
            c_ALU_ORR: w_result = bus.op_a | bus.op_b;
            c_ALU_ADD: w_result = bus.op_a + bus.op_b;
            c_ALU_SUB: w_result = bus.op_a - bus.op_b;
            c_ALU_PSB: w_result = bus.op_b;
            c_ALU_NOR: w_result = ~(bus.op_a | bus.op_b);
            default:   w_result = '0;
        endcase
    end

    // The left shift drops offset's top two bits, matching the word-to-byte
    // conversion of a sign-extended word offset; sums wrap silently.
    assign w_pc_plus4      = bus.pc + c_FOUR;
    assign w_branch_target = bus.pc + (bus.offset << 2);

    // Inputs are captured every edge; in_valid only travels to out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_alu_ctl       <= 4'b0000;
            r_result        <= '0;
            r_zero          <= 1'b1;
            r_pc_plus4      <= '0;
            r_branch_target <= '0;
        end else begin
            r_out_valid     <= bus.in_valid;
            r_alu_ctl       <= w_alu_ctl;
            r_result        <= w_result;
            r_zero          <= (w_result == '0);
            r_pc_plus4      <= w_pc_plus4;
            r_branch_target <= w_branch_target;
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.alu_ctl       = r_alu_ctl;
    assign bus.result        = r_result;
    assign bus.zero          = r_zero;
    assign bus.pc_plus4      = r_pc_plus4;
    assign bus.branch_target = r_branch_target;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_stage
// Description : Self-checking bench for exec_stage. Directed cases followed
//               by randomized operations compared against a behavioural
//               model of the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_stage;

    localparam int DATA_W = 64;

    localparam logic [9:0] c_FN_ADD = 10'b1000101100;
    localparam logic [9:0] c_FN_SUB = 10'b1100101100;
    localparam logic [9:0] c_FN_AND = 10'b1000101000;
    localparam logic [9:0] c_FN_ORR = 10'b1010101000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    exec_stage_if #(.DATA_W(DATA_W)) bus ();

    exec_stage #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: operation chosen by name, then evaluated.
    typedef enum {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_PASSB, OP_BAD} op_e;

    function automatic op_e decode(input logic [1:0] aop, input logic [9:0] f);
        if (aop == 2'd0) return OP_ADD;
        if (aop == 2'd1) return OP_PASSB;
        if (aop == 2'd2) begin
            if (f == c_FN_ADD) return OP_ADD;
            if (f == c_FN_SUB) return OP_SUB;
            if (f == c_FN_AND) return OP_AND;
            if (f == c_FN_ORR) return OP_ORR;
        end
        return OP_BAD;
    endfunction

    task automatic apply(input string tag, input logic r, input logic v,
                         input logic [1:0] aop, input logic [9:0] f,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] p, input logic [63:0] o);
        op_e         op;
        logic [3:0]  e_ctl;
        logic [63:0] e_res;
        rst          = r;
        bus.in_valid = v;
        bus.alu_op   = aop;
        bus.funct    = f;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.pc       = p;
        bus.offset   = o;
        @(posedge clk);
        #1;
        if (r) begin
            check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
            check({tag, ".alu_ctl"},   64'(bus.alu_ctl),   64'd0);
            check({tag, ".result"},    bus.result,         64'd0);
            check({tag, ".zero"},      64'(bus.zero),      64'd1);
            check({tag, ".pc_plus4"},  bus.pc_plus4,       64'd0);
            check({tag, ".br_tgt"},    bus.branch_target,  64'd0);
        end else begin
            op = decode(aop, f);
            case (op)
                OP_ADD:   begin e_ctl = 4'd2;  e_res = a + b; end
                OP_SUB:   begin e_ctl = 4'd6;  e_res = a - b; end
                OP_AND:   begin e_ctl = 4'd0;  e_res = a & b; end
                OP_ORR:   begin e_ctl = 4'd1;  e_res = a | b; end
                OP_PASSB: begin e_ctl = 4'd7;  e_res = b;     end
                default:  begin e_ctl = 4'd15; e_res = 64'd0; end
            endcase
            check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
            check({tag, ".alu_ctl"},   64'(bus.alu_ctl),   64'(e_ctl));
            check({tag, ".result"},    bus.result,         e_res);
            check({tag, ".zero"},      64'(bus.zero),      64'(e_res == 64'd0));
            check({tag, ".pc_plus4"},  bus.pc_plus4,       p + 64'd4);
            check({tag, ".br_tgt"},    bus.branch_target,  p + o * 64'd4);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [9:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  aop;

        // Reset held two cycles while valid operations are offered
        apply("rst0", 1'b1, 1'b1, 2'b10, c_FN_ADD, rnd64(), rnd64(), rnd64(), rnd64());
        apply("rst1", 1'b1, 1'b1, 2'b00, 10'h0,    rnd64(), rnd64(), rnd64(), rnd64());

        // R-type back to back
        apply("radd", 1'b0, 1'b1, 2'b10, c_FN_ADD, 64'h0F0F, 64'h00FF, 64'h0, 64'h0);
        check("radd.const", bus.result, 64'h100E);
        apply("rsub", 1'b0, 1'b1, 2'b10, c_FN_SUB, 64'h0F0F, 64'h00FF, 64'h0, 64'h0);
        check("rsub.const", bus.result, 64'h0E10);
        apply("rand", 1'b0, 1'b1, 2'b10, c_FN_AND, 64'h0F0F, 64'h00FF, 64'h0, 64'h0);
        check("rand.const", bus.result, 64'h000F);
        apply("rorr", 1'b0, 1'b1, 2'b10, c_FN_ORR, 64'h0F0F, 64'h00FF, 64'h0, 64'h0);
        check("rorr.const", bus.result, 64'h0FFF);

        // Wrap and zero
        apply("wrap", 1'b0, 1'b1, 2'b10, c_FN_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h0);
        check("wrap.zero", 64'(bus.zero), 64'd1);
        apply("neg",  1'b0, 1'b1, 2'b10, c_FN_SUB, 64'd5, 64'd7, 64'h0, 64'h0);
        check("neg.const", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);

        // Fixed decode paths
        apply("ldst", 1'b0, 1'b1, 2'b00, 10'h3FF, 64'd10, 64'd20, 64'h0, 64'h0);
        apply("cbz0", 1'b0, 1'b1, 2'b01, 10'h0,   64'd55, 64'd0,  64'h0, 64'h0);
        apply("cbz9", 1'b0, 1'b0, 2'b01, 10'h0,   64'd55, 64'd9,  64'h0, 64'h0);
        apply("op11", 1'b0, 1'b1, 2'b11, c_FN_ADD, 64'd3, 64'd4,  64'h0, 64'h0);
        apply("fn0",  1'b0, 1'b1, 2'b10, 10'h0,   64'd3, 64'd4,   64'h0, 64'h0);

        // PC adders
        apply("pc3",  1'b0, 1'b1, 2'b00, 10'h0, 64'd0, 64'd0, 64'h100, 64'd3);
        check("pc3.bt", bus.branch_target, 64'h10C);
        apply("pcm2", 1'b0, 1'b1, 2'b00, 10'h0, 64'd0, 64'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE);
        check("pcm2.bt", bus.branch_target, 64'hF8);
        apply("pcwr", 1'b0, 1'b1, 2'b00, 10'h0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1);
        check("pcwr.p4", bus.pc_plus4, 64'd0);

        // Reset mid-stream: the op offered with reset is discarded
        apply("ms1", 1'b0, 1'b1, 2'b10, c_FN_ORR, 64'h1234, 64'h8000, 64'h40, 64'd2);
        apply("ms2", 1'b1, 1'b1, 2'b10, c_FN_ADD, 64'h1111, 64'h2222, 64'h80, 64'd5);
        apply("ms3", 1'b0, 1'b1, 2'b10, c_FN_SUB, 64'h9999, 64'h1111, 64'hC0, 64'd7);

        // Randomized operations, with occasional reset
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: f = c_FN_ADD;
                1: f = c_FN_SUB;
                2: f = c_FN_AND;
                3: f = c_FN_ORR;
                default: f = 10'($urandom());
            endcase
            aop = 2'($urandom());
            a = rnd64();
            b = ($urandom_range(0, 7) == 0) ? a : rnd64();
            if ($urandom_range(0, 9) == 0) b = 64'd0;
            apply($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0), 1'($urandom()),
                  aop, f, a, b, rnd64(), rnd64());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
